// File: rtl/fft_peak_detect.sv
// Peak-bin finder for the serial 4-point FFT output stream: L1 magnitude per bin,
// one registered result per frame, plus a framing-error pulse.
module fft_peak_detect #(
    parameter int unsigned DW      = 6,
    parameter int unsigned NBINS   = 4,
    parameter int unsigned THRESH  = 8,
    parameter int unsigned SKIP_DC = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [DW-1:0]               in_data,
    input  logic                        in_sof,
    input  logic                        in_real,
    output logic                        peak_valid,
    output logic [$clog2(NBINS)-1:0]    peak_bin,
    output logic [DW:0]                 peak_mag,
    output logic                        peak_over,
    output logic                        sync_err
);

    localparam int unsigned MW   = DW + 1;
    localparam int unsigned BINW = $clog2(NBINS);
    localparam int unsigned IDXW = $clog2(2 * NBINS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * NBINS - 1);
    localparam logic [MW-1:0]   THRESH_V = MW'(THRESH);
    localparam logic [BINW-1:0] FIRST_BIN = BINW'((SKIP_DC != 0) ? 1 : 0);

    typedef enum logic {HUNT, RUN} state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DW-1:0]     re_q, re_d;
    logic [MW-1:0]     max_q, max_d;
    logic [BINW-1:0]   maxbin_q, maxbin_d;
    logic              peak_valid_q, peak_valid_d;
    logic [BINW-1:0]   peak_bin_q, peak_bin_d;
    logic [MW-1:0]     peak_mag_q, peak_mag_d;
    logic              peak_over_q, peak_over_d;
    logic              sync_err_q, sync_err_d;

    logic [BINW-1:0]   bin_c;
    logic [MW-1:0]     mag_c;
    logic [MW-1:0]     cand_max_c;
    logic [BINW-1:0]   cand_bin_c;

    // abs() widened by one bit so the most negative word maps to +2^(DW-1)
    function automatic logic [MW-1:0] abs_w(input logic [DW-1:0] x);
        logic [MW-1:0] e;
        e = {x[DW-1], x};
        return x[DW-1] ? MW'(~e + MW'(1)) : e;
    endfunction

    assign bin_c = idx_q[IDXW-1:1];
    assign mag_c = abs_w(re_q) + abs_w(in_data);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        re_d         = re_q;
        max_d        = max_q;
        maxbin_d     = maxbin_q;
        peak_valid_d = 1'b0;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_over_d  = peak_over_q;
        sync_err_d   = 1'b0;

        // First eligible bin loads unconditionally; strict > keeps the lowest bin on ties
        cand_max_c = max_q;
        cand_bin_c = maxbin_q;
        if (!((SKIP_DC != 0) && (bin_c == '0))) begin
            if ((bin_c == FIRST_BIN) || (mag_c > max_q)) begin
                cand_max_c = mag_c;
                cand_bin_c = bin_c;
            end
        end

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof && in_real) begin
                        state_d = RUN;
                        idx_d   = IDXW'(1);
                        re_d    = in_data;
                    end
                end
                RUN: begin
                    if (in_sof && (idx_q != '0)) begin
                        sync_err_d = 1'b1;
                        if (in_real) begin
                            idx_d = IDXW'(1);
                            re_d  = in_data;
                        end else begin
                            state_d = HUNT;
                            idx_d   = '0;
                        end
                    end else if (!in_sof && (idx_q == '0)) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        idx_d      = '0;
                    end else if (in_real == idx_q[0]) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                        if (!idx_q[0]) begin
                            re_d = in_data;
                        end else begin
                            max_d    = cand_max_c;
                            maxbin_d = cand_bin_c;
                            if (idx_q == LAST_IDX) begin
                                peak_valid_d = 1'b1;
                                peak_bin_d   = cand_bin_c;
                                peak_mag_d   = cand_max_c;
                                peak_over_d  = (cand_max_c >= THRESH_V);
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            re_q         <= '0;
            max_q        <= '0;
            maxbin_q     <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_over_q  <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            re_q         <= re_d;
            max_q        <= max_d;
            maxbin_q     <= maxbin_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_over_q  <= peak_over_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_over  = peak_over_q;
    assign sync_err   = sync_err_q;

endmodule
